// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction fields and ALU flag in, datapath enables and mux selects out.
// The control unit takes the master modport and the datapath takes the slave modport.
interface multicycle_control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       pc_load;
    logic       mem_write;
    logic       ins_load;
    logic       reg_write;
    logic       regA_load;
    logic       regB_load;
    logic       aluout_load;
    logic       mdr_load;
    logic       epc_load;
    logic       mux_memdata;
    logic       mux_alusrcA;
    logic [1:0] mux_pcin;
    logic [1:0] mux_IorD;
    logic [1:0] mux_regdst;
    logic [1:0] mux_alusrcB;
    logic [2:0] mux_mem2reg;
    logic [2:0] alu_op;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero,
        output pc_load, mem_write, ins_load, reg_write, regA_load, regB_load,
               aluout_load, mdr_load, epc_load, mux_memdata, mux_alusrcA,
               mux_pcin, mux_IorD, mux_regdst, mux_alusrcB, mux_mem2reg,
               alu_op, illegal_op
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_load, mem_write, ins_load, reg_write, regA_load, regB_load,
               aluout_load, mdr_load, epc_load, mux_memdata, mux_alusrcA,
               mux_pcin, mux_IorD, mux_regdst, mux_alusrcB, mux_mem2reg,
               alu_op, illegal_op
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory wait states, load/store, branch/jump and an illegal-op trap.
// Outputs are decoded from the registered state; only the BRANCH pc_load also looks at the zero flag.
module multicycle_control_unit #(
    parameter int MEM_WAIT      = 3,
    parameter bit ENABLE_EXCEPT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_unit_if.master   bus
);

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_IR_LOAD, S_DECODE, S_R_EXEC, S_I_EXEC, S_ALU_WB, S_LUI_WB,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_EXCEPT
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT - 1);

    state_t     r_state;
    logic [3:0] r_wait_cnt;
    logic       w_wait_done;
    logic       w_r_legal;
    logic [2:0] w_r_alu_op;
    state_t     w_illegal_next;
    state_t     w_decode_next;

    assign w_wait_done    = (r_wait_cnt == LAST_WAIT);
    assign w_illegal_next = ENABLE_EXCEPT ? S_EXCEPT : S_FETCH;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_r_legal  = 1'b1;
        w_r_alu_op = 3'd0;
        case (bus.funct)
            6'h20:   w_r_alu_op = 3'd1;
            6'h22:   w_r_alu_op = 3'd2;
            6'h24:   w_r_alu_op = 3'd3;
            6'h25:   w_r_alu_op = 3'd4;
            6'h2a:   w_r_alu_op = 3'd7;
            default: w_r_legal  = 1'b0;
        endcase

        w_decode_next = w_illegal_next;
        case (bus.opcode)
            6'h00:        w_decode_next = w_r_legal ? S_R_EXEC : w_illegal_next;
            6'h08:        w_decode_next = S_I_EXEC;
            6'h0f:        w_decode_next = S_LUI_WB;
            6'h23, 6'h2b: w_decode_next = S_MEM_ADDR;
            6'h04, 6'h05: w_decode_next = S_BRANCH;
            6'h02:        w_decode_next = S_JUMP;
            default:      w_decode_next = w_illegal_next;
        endcase
    end

    // NOTE: state and counter use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_INIT;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_INIT:    r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_wait_done) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_IR_LOAD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_IR_LOAD: r_state <= S_DECODE;
                S_DECODE:  r_state <= w_decode_next;
                S_R_EXEC,
                S_I_EXEC:  r_state <= S_ALU_WB;
                S_MEM_ADDR: r_state <= (bus.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (w_wait_done) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_MEM_WB;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_MEM_WR: begin
                    if (w_wait_done) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_FETCH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_ALU_WB, S_LUI_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_EXCEPT:
                    r_state <= S_FETCH;
                default: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_FETCH;
                end
            endcase
        end
    end

    // Everything is held at zero while reset is low, including the cycle INIT is entered.
    always_comb begin
        bus.pc_load     = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ins_load    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.regA_load   = 1'b0;
        bus.regB_load   = 1'b0;
        bus.aluout_load = 1'b0;
        bus.mdr_load    = 1'b0;
        bus.epc_load    = 1'b0;
        bus.mux_memdata = 1'b0;
        bus.mux_alusrcA = 1'b0;
        bus.mux_pcin    = 2'd0;
        bus.mux_IorD    = 2'd0;
        bus.mux_regdst  = 2'd0;
        bus.mux_alusrcB = 2'd0;
        bus.mux_mem2reg = 3'd0;
        bus.alu_op      = 3'd0;
        bus.illegal_op  = 1'b0;
        if (rst) begin
            case (r_state)
                S_INIT: begin
                    bus.reg_write   = 1'b1;
                    bus.mux_regdst  = 2'd2;
                    bus.mux_mem2reg = 3'd6;
                end
                S_IR_LOAD: begin
                    bus.ins_load    = 1'b1;
                    bus.pc_load     = 1'b1;
                    bus.mux_alusrcB = 2'd1;
                    bus.alu_op      = 3'd1;
                end
                S_DECODE: begin
                    bus.regA_load   = 1'b1;
                    bus.regB_load   = 1'b1;
                    bus.aluout_load = 1'b1;
                    bus.mux_alusrcB = 2'd3;
                    bus.alu_op      = 3'd1;
                end
                S_R_EXEC: begin
                    bus.aluout_load = 1'b1;
                    bus.mux_alusrcA = 1'b1;
                    bus.alu_op      = w_r_alu_op;
                end
                S_I_EXEC, S_MEM_ADDR: begin
                    bus.aluout_load = 1'b1;
                    bus.mux_alusrcA = 1'b1;
                    bus.mux_alusrcB = 2'd2;
                    bus.alu_op      = 3'd1;
                end
                S_ALU_WB: begin
                    bus.reg_write   = 1'b1;
                    bus.mux_mem2reg = 3'd1;
                    bus.mux_regdst  = (bus.opcode == 6'h00) ? 2'd1 : 2'd0;
                end
                S_LUI_WB: begin
                    bus.reg_write   = 1'b1;
                    bus.mux_mem2reg = 3'd2;
                end
                S_MEM_RD: begin
                    bus.mux_IorD    = 2'd1;
                    bus.mdr_load    = w_wait_done;
                end
                S_MEM_WB:  bus.reg_write = 1'b1;
                S_MEM_WR: begin
                    bus.mux_IorD    = 2'd1;
                    bus.mem_write   = 1'b1;
                end
                S_BRANCH: begin
                    bus.mux_alusrcA = 1'b1;
                    bus.alu_op      = 3'd2;
                    bus.mux_pcin    = 2'd1;
                    bus.pc_load     = ((bus.opcode == 6'h04) &&  bus.zero) ||
                                      ((bus.opcode == 6'h05) && !bus.zero);
                end
                S_JUMP: begin
                    bus.pc_load     = 1'b1;
                    bus.mux_pcin    = 2'd2;
                end
                S_EXCEPT: begin
                    bus.epc_load    = 1'b1;
                    bus.pc_load     = 1'b1;
                    bus.mux_pcin    = 2'd3;
                    bus.illegal_op  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Random instruction stream for two configurations, each checked cycle by cycle
// against an expected-output sequence built from the instruction-level behaviour.
module tb_multicycle_control_unit;

    localparam int MW_A  = 3;
    localparam int MW_B  = 1;
    localparam bit EXC_A = 1'b1;
    localparam bit EXC_B = 1'b0;

    typedef struct packed {
        logic       pc_load, mem_write, ins_load, reg_write, regA_load, regB_load;
        logic       aluout_load, mdr_load, epc_load, mux_memdata, mux_alusrcA;
        logic [1:0] mux_pcin, mux_IorD, mux_regdst, mux_alusrcB;
        logic [2:0] mux_mem2reg, alu_op;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_unit_if ifa ();
    multicycle_control_unit_if ifb ();

    multicycle_control_unit #(.MEM_WAIT(MW_A), .ENABLE_EXCEPT(EXC_A)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master));
    multicycle_control_unit #(.MEM_WAIT(MW_B), .ENABLE_EXCEPT(EXC_B)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master));

    logic [5:0] op_drv [2];
    logic [5:0] fn_drv [2];
    logic       z_drv  [2];

    assign ifa.opcode = op_drv[0];
    assign ifa.funct  = fn_drv[0];
    assign ifa.zero   = z_drv[0];
    assign ifb.opcode = op_drv[1];
    assign ifb.funct  = fn_drv[1];
    assign ifb.zero   = z_drv[1];

    ctl_t obs [2];
    assign obs[0] = {ifa.pc_load, ifa.mem_write, ifa.ins_load, ifa.reg_write, ifa.regA_load,
                     ifa.regB_load, ifa.aluout_load, ifa.mdr_load, ifa.epc_load, ifa.mux_memdata,
                     ifa.mux_alusrcA, ifa.mux_pcin, ifa.mux_IorD, ifa.mux_regdst, ifa.mux_alusrcB,
                     ifa.mux_mem2reg, ifa.alu_op, ifa.illegal_op};
    assign obs[1] = {ifb.pc_load, ifb.mem_write, ifb.ins_load, ifb.reg_write, ifb.regA_load,
                     ifb.regB_load, ifb.aluout_load, ifb.mdr_load, ifb.epc_load, ifb.mux_memdata,
                     ifb.mux_alusrcA, ifb.mux_pcin, ifb.mux_IorD, ifb.mux_regdst, ifb.mux_alusrcB,
                     ifb.mux_mem2reg, ifb.alu_op, ifb.illegal_op};

    ctl_t   exp_q [2][$];
    instr_t dir_q [2][$];
    int     n_vec = 0;
    int     n_mis = 0;
    int     cyc   = 0;

    task automatic check(input string tag, input ctl_t got, input ctl_t want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'd1;
            6'h22:   return 3'd2;
            6'h24:   return 3'd3;
            6'h25:   return 3'd4;
            6'h2a:   return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic ctl_t init_vec();
        ctl_t c = '0;
        c.reg_write = 1'b1; c.mux_regdst = 2'd2; c.mux_mem2reg = 3'd6;
        return c;
    endfunction

    // Expected per-cycle outputs of one whole instruction, starting at its first FETCH cycle.
    function automatic void build(input int d, input instr_t in);
        int   mw  = (d == 0) ? MW_A : MW_B;
        bit   exc = (d == 0) ? EXC_A : EXC_B;
        ctl_t c;
        for (int i = 0; i < mw; i++) exp_q[d].push_back('0);
        c = '0; c.ins_load = 1; c.pc_load = 1; c.mux_alusrcB = 2'd1; c.alu_op = 3'd1;
        exp_q[d].push_back(c);
        c = '0; c.regA_load = 1; c.regB_load = 1; c.aluout_load = 1; c.mux_alusrcB = 2'd3; c.alu_op = 3'd1;
        exp_q[d].push_back(c);
        if ((in.op == 6'h00 && r_alu(in.fn) != 3'd0) || in.op == 6'h08) begin
            c = '0; c.aluout_load = 1; c.mux_alusrcA = 1;
            c.mux_alusrcB = (in.op == 6'h08) ? 2'd2 : 2'd0;
            c.alu_op      = (in.op == 6'h08) ? 3'd1 : r_alu(in.fn);
            exp_q[d].push_back(c);
            c = '0; c.reg_write = 1; c.mux_mem2reg = 3'd1;
            c.mux_regdst = (in.op == 6'h00) ? 2'd1 : 2'd0;
            exp_q[d].push_back(c);
        end else if (in.op == 6'h0f) begin
            c = '0; c.reg_write = 1; c.mux_mem2reg = 3'd2;
            exp_q[d].push_back(c);
        end else if (in.op == 6'h23 || in.op == 6'h2b) begin
            c = '0; c.aluout_load = 1; c.mux_alusrcA = 1; c.mux_alusrcB = 2'd2; c.alu_op = 3'd1;
            exp_q[d].push_back(c);
            for (int i = 0; i < mw; i++) begin
                c = '0; c.mux_IorD = 2'd1;
                if (in.op == 6'h2b) c.mem_write = 1;
                else                c.mdr_load  = (i == mw - 1);
                exp_q[d].push_back(c);
            end
            if (in.op == 6'h23) begin
                c = '0; c.reg_write = 1;
                exp_q[d].push_back(c);
            end
        end else if (in.op == 6'h04 || in.op == 6'h05) begin
            c = '0; c.mux_alusrcA = 1; c.alu_op = 3'd2; c.mux_pcin = 2'd1;
            c.pc_load = (in.op == 6'h04) ? in.z : ~in.z;
            exp_q[d].push_back(c);
        end else if (in.op == 6'h02) begin
            c = '0; c.pc_load = 1; c.mux_pcin = 2'd2;
            exp_q[d].push_back(c);
        end else if (exc) begin
            c = '0; c.epc_load = 1; c.pc_load = 1; c.mux_pcin = 2'd3; c.illegal_op = 1;
            exp_q[d].push_back(c);
        end
    endfunction

    function automatic instr_t pick();
        logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
        logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        instr_t in;
        int     r = $urandom_range(0, 9);
        in.op = (r < 8) ? ops[r] : (r == 8 ? 6'($urandom) : 6'h00);
        in.fn = ($urandom_range(0, 4) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
        in.z  = 1'($urandom);
        return in;
    endfunction

    task automatic step();
        instr_t in;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() == 0) begin
                in = (dir_q[d].size() != 0) ? dir_q[d].pop_front() : pick();
                op_drv[d] = in.op;
                fn_drv[d] = in.fn;
                z_drv[d]  = in.z;
                build(d, in);
            end
        end
        #1;
        for (int d = 0; d < 2; d++)
            check($sformatf("dut%0d cyc%0d", d, cyc), obs[d], exp_q[d].pop_front());
    endtask

    task automatic reset_sequence(input string tag);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) check($sformatf("%s rst%0d dut%0d", tag, k, d), obs[d], '0);
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            check($sformatf("%s init dut%0d", tag, d), obs[d], init_vec());
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            op_drv[d] = '0; fn_drv[d] = '0; z_drv[d] = 1'b0;
        end
        reset_sequence("por");

        // Store on dut0, reset lands on the second MEM_WR cycle.
        dir_q[0].push_back('{op: 6'h2b, fn: 6'h00, z: 1'b0});
        for (int k = 0; k < MW_A + 5; k++) step();
        reset_sequence("midwr");

        dir_q[0].push_back('{op: 6'h00, fn: 6'h22, z: 1'b0});
        dir_q[0].push_back('{op: 6'h23, fn: 6'h00, z: 1'b0});
        dir_q[0].push_back('{op: 6'h2b, fn: 6'h00, z: 1'b0});
        dir_q[0].push_back('{op: 6'h04, fn: 6'h00, z: 1'b1});
        dir_q[0].push_back('{op: 6'h05, fn: 6'h00, z: 1'b1});
        dir_q[0].push_back('{op: 6'h3f, fn: 6'h00, z: 1'b0});
        dir_q[1].push_back('{op: 6'h3f, fn: 6'h00, z: 1'b0});
        dir_q[1].push_back('{op: 6'h23, fn: 6'h00, z: 1'b0});
        dir_q[1].push_back('{op: 6'h2b, fn: 6'h00, z: 1'b0});
        dir_q[1].push_back('{op: 6'h00, fn: 6'h3c, z: 1'b0});
        for (int k = 0; k < 2000; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised successor to the existing multicycle MIPS control FSM.
- Adds a configurable memory wait-state count, load/store, branch and jump sequencing, a wider R-type decode, and an illegal-instruction trap.
- Sits between the instruction register (opcode/funct), the ALU zero flag and the datapath mux/load enables.
- All outputs are Moore-decoded from the registered state; the only exception is the BRANCH pc_load term, which uses the ALU zero flag.

Parameters:
- MEM_WAIT, 3: cycles each memory access is held before its data is used; legal range 1..15.
- ENABLE_EXCEPT, 1: 1 = illegal opcode/funct enters EXCEPT; 0 = illegal instruction is treated as NOP and returns to FETCH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (combinational, same cycle)
- pc_load, mem_write, ins_load, reg_write, regA_load, regB_load, aluout_load, mdr_load, epc_load  out  1 each  register and memory enables
- mux_memdata, mux_alusrcA  out  1 each  mux selects
- mux_pcin, mux_IorD, mux_regdst, mux_alusrcB  out  2 each  mux selects
- mux_mem2reg, alu_op  out  3 each  mux select / ALU function
- illegal_op  out  1  one-cycle pulse while in EXCEPT

Behaviour:
- Reset: sampled only at a rising clk edge with rst=0; clears the wait counter and forces state INIT, mid-operation included. While rst=0 every output is 0.
- Default value of every output in every state is 0; each state lists only its non-zero outputs.
- Encodings:
  - alusrcA: 0 PC, 1 regA.
  - alusrcB: 0 regB, 1 const 4, 2 sext(imm), 3 sext(imm)<<2.
  - IorD: 0 PC, 1 ALUOut.
  - pcin: 0 ALU result, 1 ALUOut, 2 jump target, 3 exception vector.
  - regdst: 0 rt, 1 rd, 2 $29.
  - mem2reg: 0 MDR, 1 ALUOut, 2 imm<<16, 6 stack-init constant.
  - alu_op: 0 pass, 1 add, 2 sub, 3 and, 4 or, 7 slt.
- States and transitions:
  - INIT: reg_write=1, regdst=2, mem2reg=6. Next FETCH.
  - FETCH: IorD=0. Wait counter counts 0..MEM_WAIT-1; on count MEM_WAIT-1, clear counter and go to IR_LOAD.
  - IR_LOAD: ins_load=1, pc_load=1, alusrcA=0, alusrcB=1, alu_op=1, pcin=0. Next DECODE.
  - DECODE: regA_load=1, regB_load=1, aluout_load=1, alusrcB=3, alu_op=1 (precomputes branch target). Next state by opcode:
    - 0x00 → R_EXEC if funct ∈ {0x20,0x22,0x24,0x25,0x2a}, else illegal.
    - 0x08 → I_EXEC.
    - 0x0f → LUI_WB.
    - 0x23 or 0x2b → MEM_ADDR.
    - 0x04 or 0x05 → BRANCH.
    - 0x02 → JUMP.
    - Anything else → illegal. Illegal goes to EXCEPT if ENABLE_EXCEPT=1, else FETCH.
  - R_EXEC: aluout_load=1, alusrcA=1, alusrcB=0, alu_op = 1/2/3/4/7 for funct 0x20/0x22/0x24/0x25/0x2a. Next ALU_WB.
  - I_EXEC: aluout_load=1, alusrcA=1, alusrcB=2, alu_op=1. Next ALU_WB.
  - ALU_WB: reg_write=1, mem2reg=1, regdst = 1 if opcode==0 else 0. Next FETCH.
  - LUI_WB: reg_write=1, regdst=0, mem2reg=2. Next FETCH.
  - MEM_ADDR: aluout_load=1, alusrcA=1, alusrcB=2, alu_op=1. Next MEM_RD if opcode 0x23, MEM_WR if 0x2b.
  - MEM_RD: IorD=1; mdr_load=1 only on the final wait count. Holds MEM_WAIT cycles, then MEM_WB.
  - MEM_WB: reg_write=1, regdst=0, mem2reg=0. Next FETCH.
  - MEM_WR: IorD=1, mux_memdata=0; mem_write=1 on every cycle of the MEM_WAIT-cycle hold, so the address and data stay stable for the whole write. Next FETCH.
  - BRANCH: alusrcA=1, alusrcB=0, alu_op=2, pcin=1. pc_load = (opcode==0x04 & zero) | (opcode==0x05 & ~zero). Next FETCH.
  - JUMP: pc_load=1, pcin=2. Next FETCH.
  - EXCEPT: epc_load=1, pc_load=1, pcin=3, illegal_op=1. Next FETCH.
- Instruction latency in cycles, including fetch:
  - R-type / addi: MEM_WAIT+4.
  - lui, beq/bne, j: MEM_WAIT+3.
  - lw: 2·MEM_WAIT+4.
  - sw: 2·MEM_WAIT+3.
- Wait counter width is 4 bits and it is cleared on every state exit. With MEM_WAIT=1, FETCH, MEM_RD and MEM_WR each last exactly 1 cycle.
- Undefined state encodings go to FETCH.

Test Plan:
- rst=0 for 2 cycles mid-MEM_WR → mem_write=0 immediately after the edge; the next states are INIT (reg_write=1, regdst=2, mem2reg=6), then FETCH.
- MEM_WAIT=3, opcode 0x00, funct 0x22 → IR_LOAD on cycle 4 after FETCH entry, alu_op=2 in R_EXEC, reg_write=1 with regdst=1 in ALU_WB; total 7 cycles.
- opcode 0x23 (lw), MEM_WAIT=3 → mdr_load=1 only on the 3rd MEM_RD cycle, then reg_write=1 with mem2reg=0; total 10 cycles.
- opcode 0x2b (sw) → mem_write=1 for exactly 3 consecutive cycles with IorD=1; reg_write is never asserted.
- opcode 0x04 with zero=1 → pc_load=1, pcin=1. opcode 0x05 with zero=1 → pc_load=0, then FETCH.
- opcode 0x3f: with ENABLE_EXCEPT=1 → a single cycle of illegal_op=1, epc_load=1, pcin=3. With ENABLE_EXCEPT=0 → returns to FETCH directly after DECODE with no pc_load.
